// File: rtl/sram_rmw_512x32_front.sv
// Bit-write front end for the 512x32 whole-word SRAM macro.
// Reads and full-word writes go straight through. A partial-mask write becomes
// a pre-read followed by a merged whole-word write, and the client is stalled
// for the merge cycle.
module sram_rmw_512x32_front #(
  parameter int unsigned ADDR_W = 9,
  parameter int unsigned DATA_W = 32,
  parameter int unsigned CNT_W  = 16
) (
  input  logic              MEMCLK,
  input  logic              RESET,
  input  logic              CE,
  input  logic [ADDR_W-1:0] A,
  input  logic              RDWEN,
  input  logic [DATA_W-1:0] BW,
  input  logic [DATA_W-1:0] DIN,
  output logic              READY,
  output logic [DATA_W-1:0] DOUT,
  output logic              DOUT_VAL,
  output logic [CNT_W-1:0]  RMW_COUNT,
  output logic              SRAM_CE,
  output logic [ADDR_W-1:0] SRAM_A,
  output logic              SRAM_RDWEN,
  output logic [DATA_W-1:0] SRAM_BW,
  output logic [DATA_W-1:0] SRAM_DIN,
  input  logic [DATA_W-1:0] SRAM_DOUT
);

  typedef enum logic {IDLE, MERGE} state_t;

  state_t              state, state_nx;
  logic                rd_pend;
  logic [ADDR_W-1:0]   hold_a;
  logic [DATA_W-1:0]   hold_bw;
  logic [DATA_W-1:0]   hold_din;
  logic [CNT_W-1:0]    rmw_cnt;
  logic                req_rd, req_full, req_part;

  // Classify the request offered this cycle (only meaningful while idle).
  always_comb begin
    req_rd   = 1'b0;
    req_full = 1'b0;
    req_part = 1'b0;
    if (state == IDLE && CE) begin
      req_rd   = RDWEN;
      req_full = ~RDWEN & (BW == '1);
      req_part = ~RDWEN & (BW != '0) & (BW != '1);
    end
  end

  // State register.
  always_ff @(posedge MEMCLK or posedge RESET) begin
    if (RESET) state <= IDLE;
    else       state <= state_nx;
  end

  // Next state: a partial write spends exactly one cycle in MERGE.
  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (req_part) state_nx = MERGE;
      MERGE:   state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // Read-pending flag, hold registers and saturating RMW counter.
  always_ff @(posedge MEMCLK or posedge RESET) begin
    if (RESET) begin
      rd_pend  <= 1'b0;
      hold_a   <= '0;
      hold_bw  <= '0;
      hold_din <= '0;
      rmw_cnt  <= '0;
    end else begin
      rd_pend <= req_rd;
      if (req_part) begin
        hold_a   <= A;
        hold_bw  <= BW;
        hold_din <= DIN;
      end
      if (state == MERGE && rmw_cnt != '1) rmw_cnt <= rmw_cnt + CNT_W'(1);
    end
  end

  // SRAM and client outputs; IDLE passes client inputs through, MERGE uses held values.
  always_comb begin
    READY      = (state == IDLE);
    SRAM_CE    = 1'b0;
    SRAM_A     = A;
    SRAM_RDWEN = 1'b1;
    SRAM_BW    = '1;
    SRAM_DIN   = DIN;
    case (state)
      IDLE: begin
        SRAM_CE    = req_rd | req_full | req_part;
        SRAM_RDWEN = ~req_full;
      end
      MERGE: begin
        SRAM_CE    = 1'b1;
        SRAM_A     = hold_a;
        SRAM_RDWEN = 1'b0;
        SRAM_DIN   = (SRAM_DOUT & ~hold_bw) | (hold_din & hold_bw);
      end
      default: ;
    endcase
    DOUT_VAL  = rd_pend;
    DOUT      = rd_pend ? SRAM_DOUT : '0;
    RMW_COUNT = rmw_cnt;
  end

endmodule

// File: tb/tb_sram_rmw_512x32_front.sv
// Bench for sram_rmw_512x32_front: behavioural SRAM, word-level reference
// memory, directed scenarios followed by randomized traffic.
module tb_sram_rmw_512x32_front;

  logic        clk = 1'b0;
  logic        RESET = 1'b1;
  logic        CE = 1'b0;
  logic [8:0]  A = '0;
  logic        RDWEN = 1'b1;
  logic [31:0] BW = '0;
  logic [31:0] DIN = '0;
  logic        READY, DOUT_VAL;
  logic [31:0] DOUT;
  logic [15:0] RMW_COUNT;
  logic        SRAM_CE, SRAM_RDWEN;
  logic [8:0]  SRAM_A;
  logic [31:0] SRAM_BW, SRAM_DIN;
  logic [31:0] sram_dout = '0;

  logic        ready4, dval4, s4_ce, s4_rdwen;
  logic [31:0] dout4, s4_bw, s4_din;
  logic [3:0]  cnt4;
  logic [8:0]  s4_a;

  always #5 clk = ~clk;

  sram_rmw_512x32_front dut (
    .MEMCLK(clk), .RESET(RESET), .CE(CE), .A(A), .RDWEN(RDWEN), .BW(BW), .DIN(DIN),
    .READY(READY), .DOUT(DOUT), .DOUT_VAL(DOUT_VAL), .RMW_COUNT(RMW_COUNT),
    .SRAM_CE(SRAM_CE), .SRAM_A(SRAM_A), .SRAM_RDWEN(SRAM_RDWEN), .SRAM_BW(SRAM_BW),
    .SRAM_DIN(SRAM_DIN), .SRAM_DOUT(sram_dout));

  // Narrow-counter copy driven identically; it sees the same read data.
  sram_rmw_512x32_front #(.ADDR_W(9), .DATA_W(32), .CNT_W(4)) dut4 (
    .MEMCLK(clk), .RESET(RESET), .CE(CE), .A(A), .RDWEN(RDWEN), .BW(BW), .DIN(DIN),
    .READY(ready4), .DOUT(dout4), .DOUT_VAL(dval4), .RMW_COUNT(cnt4),
    .SRAM_CE(s4_ce), .SRAM_A(s4_a), .SRAM_RDWEN(s4_rdwen), .SRAM_BW(s4_bw),
    .SRAM_DIN(s4_din), .SRAM_DOUT(sram_dout));

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %08h expected %08h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] mrg(input logic [31:0] old, input logic [31:0] m, input logic [31:0] d);
    return (old & ~m) | (d & m);
  endfunction

  // Behavioural bit-write SRAM macro, one-cycle read latency.
  logic [31:0] mem [512];
  int wr_count = 0;
  always @(posedge clk) begin
    if (SRAM_CE) begin
      if (SRAM_RDWEN) sram_dout <= mem[SRAM_A];
      else begin
        mem[SRAM_A] <= mrg(mem[SRAM_A], SRAM_BW, SRAM_DIN);
        wr_count    <= wr_count + 1;
      end
    end
  end

  // Reference model: what the client-visible memory and outputs must be.
  logic [31:0] ref_mem [512];
  logic        m_ready = 1'b1;
  logic        m_val = 1'b0;
  logic [31:0] m_rdata = '0;
  int          m_cnt = 0;
  logic [8:0]  h_a = '0;
  logic [31:0] h_bw = '0, h_din = '0;

  always @(posedge clk or posedge RESET) begin
    if (RESET) begin
      m_ready <= 1'b1;
      m_val   <= 1'b0;
      m_cnt   <= 0;
    end else if (!m_ready) begin
      ref_mem[h_a] <= mrg(ref_mem[h_a], h_bw, h_din);
      m_cnt   <= m_cnt + 1;
      m_ready <= 1'b1;
      m_val   <= 1'b0;
    end else begin
      m_val <= CE && RDWEN;
      if (CE) begin
        if (RDWEN) m_rdata <= ref_mem[A];
        else if (BW == 32'hFFFF_FFFF) ref_mem[A] <= DIN;
        else if (BW != 32'h0) begin
          h_a <= A; h_bw <= BW; h_din <= DIN;
          m_ready <= 1'b0;
        end
      end
    end
  end

  // Per-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin
    logic exp_ce;
    chk("ready", {31'b0, READY}, {31'b0, m_ready});
    chk("ready4", {31'b0, ready4}, {31'b0, m_ready});
    chk("dout_val", {31'b0, DOUT_VAL}, {31'b0, m_val});
    chk("dout", DOUT, m_val ? m_rdata : 32'h0);
    chk("rmw_count", {16'b0, RMW_COUNT}, (m_cnt > 65535) ? 32'hFFFF : 32'(m_cnt));
    chk("rmw_count4", {28'b0, cnt4}, (m_cnt > 15) ? 32'hF : 32'(m_cnt));
    if (!m_ready) begin
      chk("merge_ce", {31'b0, SRAM_CE}, 32'h1);
      chk("merge_rdwen", {31'b0, SRAM_RDWEN}, 32'h0);
      chk("merge_a", {23'b0, SRAM_A}, {23'b0, h_a});
      chk("merge_din", SRAM_DIN, mrg(ref_mem[h_a], h_bw, h_din));
      chk("merge_bw", SRAM_BW, 32'hFFFF_FFFF);
    end else begin
      exp_ce = !RESET && CE && (RDWEN || BW != 32'h0);
      chk("sram_ce", {31'b0, SRAM_CE}, {31'b0, exp_ce});
      if (exp_ce) begin
        chk("sram_a", {23'b0, SRAM_A}, {23'b0, A});
        chk("sram_rdwen", {31'b0, SRAM_RDWEN}, {31'b0, RDWEN || BW != 32'hFFFF_FFFF});
        if (!RDWEN && BW == 32'hFFFF_FFFF) begin
          chk("full_din", SRAM_DIN, DIN);
          chk("full_bw", SRAM_BW, 32'hFFFF_FFFF);
        end
      end
    end
  end

  // Present a request from posedge+1 and hold it until it is accepted.
  task automatic issue(input logic rd, input logic [8:0] a, input logic [31:0] m, input logic [31:0] d);
    logic rdy;
    logic acc;
    CE = 1'b1; A = a; RDWEN = rd; BW = m; DIN = d;
    acc = 1'b0;
    for (int i = 0; i < 4 && !acc; i++) begin
      @(negedge clk); rdy = READY;
      @(posedge clk); #1;
      acc = rdy;
    end
    if (!acc) chk("accept_timeout", 32'h0, 32'h1);
  endtask

  task automatic idle_cycle();
    CE = 1'b0;
    @(posedge clk); #1;
  endtask

  // Called in the cycle after a read was accepted.
  task automatic rd_check(input logic [31:0] lit);
    CE = 1'b0;
    @(negedge clk);
    chk("rd_lit_val", {31'b0, DOUT_VAL}, 32'h1);
    chk("rd_lit_data", DOUT, lit);
    @(posedge clk); #1;
  endtask

  task automatic do_reset();
    CE = 1'b0;
    RESET = 1'b1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    RESET = 1'b0;
  endtask

  initial begin
    int w0;
    for (int i = 0; i < 512; i++) begin mem[i] = '0; ref_mem[i] = '0; end
    @(posedge clk); #1;
    @(negedge clk);
    chk("reset_ready", {31'b0, READY}, 32'h1);
    chk("reset_dval", {31'b0, DOUT_VAL}, 32'h0);
    chk("reset_cnt", {16'b0, RMW_COUNT}, 32'h0);
    @(posedge clk); #1;
    RESET = 1'b0;

    // Full write then read.
    issue(1'b0, 9'h010, 32'hFFFF_FFFF, 32'hA5A5_A5A5);
    issue(1'b1, 9'h010, 32'h0, 32'h0);
    rd_check(32'hA5A5_A5A5);

    // Partial write merge.
    issue(1'b0, 9'h1FF, 32'hFFFF_FFFF, 32'h1234_5678);
    issue(1'b0, 9'h1FF, 32'h0000_FFFF, 32'hFFFF_ABCD);
    CE = 1'b0;
    @(negedge clk);
    chk("pw_ready_low", {31'b0, READY}, 32'h0);
    chk("pw_sram_din", SRAM_DIN, 32'h1234_ABCD);
    @(posedge clk); #1;
    issue(1'b1, 9'h1FF, 32'h0, 32'h0);
    rd_check(32'h1234_ABCD);
    chk("pw_count", {16'b0, RMW_COUNT}, 32'h1);

    // Null write leaves memory alone.
    issue(1'b0, 9'h005, 32'hFFFF_FFFF, 32'h0000_0055);
    issue(1'b0, 9'h005, 32'h0, 32'hFFFF_FFFF);
    issue(1'b1, 9'h005, 32'h0, 32'h0);
    rd_check(32'h0000_0055);

    // Ten back-to-back partial writes.
    do_reset();
    w0 = wr_count;
    for (int i = 0; i < 10; i++)
      issue(1'b0, 9'(i + 32), 32'h00FF_00F0 << i, $urandom);
    idle_cycle();
    chk("b2b_writes", 32'(wr_count - w0), 32'd10);
    chk("b2b_count", {16'b0, RMW_COUNT}, 32'd10);

    // Reset during MERGE aborts the write.
    issue(1'b0, 9'h020, 32'hFFFF_FFFF, 32'hDEAD_BEEF);
    w0 = wr_count;
    issue(1'b0, 9'h020, 32'h0000_00FF, 32'h0);
    CE = 1'b0;
    @(negedge clk); #1;
    RESET = 1'b1;
    @(posedge clk); #1;
    RESET = 1'b0;
    @(negedge clk);
    chk("abort_no_write", 32'(wr_count - w0), 32'd0);
    chk("abort_ready", {31'b0, READY}, 32'h1);
    chk("abort_dval", {31'b0, DOUT_VAL}, 32'h0);
    @(posedge clk); #1;
    issue(1'b1, 9'h020, 32'h0, 32'h0);
    rd_check(32'hDEAD_BEEF);

    // Counter saturation on the narrow instance.
    do_reset();
    for (int i = 0; i < 17; i++) issue(1'b0, 9'(i), 32'h0000_0F0F, $urandom);
    idle_cycle();
    chk("sat_cnt4", {28'b0, cnt4}, 32'hF);
    chk("sat_cnt16", {16'b0, RMW_COUNT}, 32'd17);
    issue(1'b0, 9'h003, 32'h8000_0001, 32'hFFFF_FFFF);
    idle_cycle();
    chk("sat_hold4", {28'b0, cnt4}, 32'hF);

    // Randomized traffic over a small address window.
    for (int n = 0; n < 400; n++) begin
      int unsigned kind;
      logic [8:0]  a;
      logic [31:0] m;
      kind = $urandom_range(0, 9);
      a = ($urandom_range(0, 7) == 0) ? 9'h1FF : 9'($urandom_range(0, 15));
      if (kind < 3)      issue(1'b1, a, $urandom, $urandom);
      else if (kind < 5) issue(1'b0, a, 32'hFFFF_FFFF, $urandom);
      else if (kind < 6) issue(1'b0, a, 32'h0, $urandom);
      else if (kind < 9) begin
        m = $urandom;
        if (m == 32'h0 || m == 32'hFFFF_FFFF) m = 32'h0000_0001;
        issue(1'b0, a, m, $urandom);
      end else idle_cycle();
    end
    idle_cycle();
    idle_cycle();

    $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL global_timeout: simulation did not complete");
    $fatal(1);
  end

endmodule
